line_refill_ctrl: RTL
=====================

// Module: line_refill_ctrl
// PURPOSE
//  Refill engine between the 2-way instruction cache and the 32-bit memory bus. Accepts a
//  line-aligned miss request, issues NrWordsPerLine single-word bus reads, assembles the
//  line and returns it to the cache with a one-cycle valid pulse.
// PARAMETERS
//  NrWordsPerLine  4    words per cache line (power of 2)
//  LineSize        128  line width in bits, = 32*NrWordsPerLine
//  TimeoutCycles   256  wait limit per bus phase; used only with REFILL_TIMEOUT_EN
// PORTS
//  clk_i         in   1         clock
//  rstn_i        in   1         reset, asynchronous, active-low
//  req_addr_i    in   32        line-aligned miss address (cache mem_addr_o)
//  req_en_i      in   1         miss request, level, held by cache until fill (mem_read_en_o)
//  line_valid_o  out  1         one-cycle pulse: line_data_o valid (cache mem_read_valid_i)
//  line_data_o   out  LineSize  assembled line, word k at [32k +: 32]
//  bus_req_o     out  1         bus read request, held until bus_gnt_i
//  bus_addr_o    out  32        word address, stable while bus_req_o high
//  bus_gnt_i     in   1         request accepted this cycle
//  bus_rvalid_i  in   1         read data valid; in order, max one outstanding
//  bus_rdata_i   in   32        read data
//  err_o         out  1         one-cycle pulse on timeout abort (tied 0 without macro)
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, word counter 0, line buffer 0, latched addr 0.
//  - States: IDLE, REQ, WAIT, DONE.
//  - IDLE: req_en_i high at edge -> latch {req_addr_i[31:4],4'b0} as base, cnt=0, go REQ.
//  - REQ: bus_req_o=1, bus_addr_o=base+4*cnt. bus_gnt_i high -> WAIT; else stay, addr held.
//  - WAIT: bus_rvalid_i high -> buffer[32*cnt +: 32]=bus_rdata_i; cnt==NrWordsPerLine-1
//    -> DONE, else cnt++ and -> REQ. bus_rvalid_i in IDLE/REQ/DONE ignored.
//  - DONE: line_valid_o=1 for exactly this cycle iff req_en_i high AND req_addr_i[31:4] ==
//    base[31:4]; else line discarded (stale fill, no pulse). Always -> IDLE. req_en_i
//    ignored in DONE (cache writes line at this edge; next cycle its hit clears req_en_i).
//  - Address changes or req_en_i drop during REQ/WAIT do not abort the fill; only DONE check.
//  - line_data_o registered, holds last buffer contents between fills.
//  - Best-case latency (gnt same cycle as req, rvalid next cycle): req_en_i sampled at edge
//    0 -> line_valid_o high in cycle 9.
//  - Counter width $clog2(NrWordsPerLine); wraps only via return to IDLE.
//  - Async reset mid-fill: immediate return to IDLE, partial line dropped, no pulse; late
//    rvalid for the aborted read ignored.
// CONFIGURATION
//  REFILL_TIMEOUT_EN defined: cycle counter cleared on entry to REQ/WAIT; reaching
//    TimeoutCycles in either state -> bus_req_o=0, err_o pulses 1 cycle, -> IDLE, no
//    line_valid_o. Counter width $clog2(TimeoutCycles+1).
//  Not defined: no counter, REQ/WAIT wait indefinitely, err_o constant 0.
// TESTING
//  1 Basic: req 0x0000_1230, gnt immediate, rvalid next cycle, data 0x11111111,
//    0x22222222,0x33333333,0x44444444 -> bus_addr 0x1230,0x1234,0x1238,0x123C; one
//    line_valid_o pulse, line_data_o=0x44444444_33333333_22222222_11111111, cycle 9.
//  2 Backpressure: bus_gnt_i low 3 cycles on word 2 -> bus_req_o high, bus_addr_o=0x1238
//    stable all 4 cycles; rvalid delayed 5 cycles -> bus_req_o low while WAIT; line correct.
//  3 Stale: req_en_i drops after word 1 -> fill completes, no line_valid_o; same for
//    req_addr_i changed to 0x2000 at DONE.
//  4 Back-to-back: new miss 0x0000_4000 first seen cycle after DONE -> new fill from
//    IDLE, exactly one pulse per fill, no refetch of 0x1230.
//  5 Reset mid-fill after 2 words, rvalid asserted 1 cycle after release -> all outputs
//    0, rvalid ignored, following fill of 0x1230 returns correct line.
//  6 REFILL_TIMEOUT_EN, TimeoutCycles=16, gnt never -> bus_req_o drops and err_o pulses
//    after 16 REQ cycles, no line_valid_o; without macro bus_req_o stays high, err_o 0.

Source files
------------

// File: rtl/line_refill_ctrl.sv
// line_refill_ctrl: instruction-cache line refill engine.
// Issues NrWordsPerLine single-word reads on the 32-bit memory bus, assembles
// the line and hands it back to the cache with a one-cycle valid pulse.
// Optional feature macro REFILL_TIMEOUT_EN: abort a fill whose bus phase
// waits TimeoutCycles cycles, pulsing err_o; without it err_o is tied 0.
module line_refill_ctrl #(
  parameter int unsigned NrWordsPerLine = 4,
  parameter int unsigned LineSize       = 32 * NrWordsPerLine,
  parameter int unsigned TimeoutCycles  = 256
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [31:0]         req_addr_i,
  input  logic                req_en_i,
  output logic                line_valid_o,
  output logic [LineSize-1:0] line_data_o,
  output logic                bus_req_o,
  output logic [31:0]         bus_addr_o,
  input  logic                bus_gnt_i,
  input  logic                bus_rvalid_i,
  input  logic [31:0]         bus_rdata_i,
  output logic                err_o
);

  localparam int unsigned CntW = (NrWordsPerLine > 1) ? $clog2(NrWordsPerLine) : 1;
  localparam int unsigned OffW = CntW + 2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [CntW-1:0]     cnt_nxt;
  logic [31:0]         base_q;
  logic [31:0]         req_base;
  logic [LineSize-1:0] buf_q;
  logic                unused_addr_bits;

  assign req_base         = {req_addr_i[31:OffW], {OffW{1'b0}}};
  assign cnt_nxt          = cnt_q + 1'b1;
  assign unused_addr_bits = ^req_addr_i[OffW-1:0];
  assign line_data_o      = buf_q;

  // The DONE-cycle check must see the cache's current request, so the pulse
  // is decoded from the registered state and the live request inputs.
  assign line_valid_o = (state_q == DONE) && req_en_i &&
                        (req_addr_i[31:OffW] == base_q[31:OffW]);

`ifdef REFILL_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

  logic [TmoW-1:0] tmo_q;
  logic            tmo_hit;
  logic            progress;

  // Last waiting cycle: the counter reaches TimeoutCycles at this edge.
  assign tmo_hit  = (tmo_q == TmoW'(TimeoutCycles - 1));
  assign progress = ((state_q == REQ)  && bus_gnt_i) ||
                    ((state_q == WAIT) && bus_rvalid_i);

  // Cycles spent waiting in the current bus phase; restarts on every phase entry.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tmo_q <= '0;
    end else if ((state_q != REQ && state_q != WAIT) || progress || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  localparam int unsigned unused_tmo_cycles = TimeoutCycles;

  assign err_o = 1'b0;
`endif

  // Refill sequencer: request each word, capture its data, report the line.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      buf_q      <= '0;
      bus_req_o  <= 1'b0;
      bus_addr_o <= '0;
`ifdef REFILL_TIMEOUT_EN
      err_o      <= 1'b0;
`endif
    end else begin
`ifdef REFILL_TIMEOUT_EN
      err_o <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_en_i) begin
            base_q     <= req_base;
            cnt_q      <= '0;
            bus_addr_o <= req_base;
            bus_req_o  <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            state_q   <= WAIT;
          end
`ifdef REFILL_TIMEOUT_EN
          else if (tmo_hit) begin
            bus_req_o <= 1'b0;
            err_o     <= 1'b1;
            state_q   <= IDLE;
          end
`endif
        end
        WAIT: begin
          if (bus_rvalid_i) begin
            buf_q[32*cnt_q +: 32] <= bus_rdata_i;
            if (cnt_q == CntW'(NrWordsPerLine - 1)) begin
              state_q <= DONE;
            end else begin
              cnt_q      <= cnt_nxt;
              bus_addr_o <= base_q + {{(30 - CntW){1'b0}}, cnt_nxt, 2'b00};
              bus_req_o  <= 1'b1;
              state_q    <= REQ;
            end
          end
`ifdef REFILL_TIMEOUT_EN
          else if (tmo_hit) begin
            err_o   <= 1'b1;
            state_q <= IDLE;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
